// File: rtl/relu_pkg.sv
// Shared FP32 types, constants and helpers for the leaky-ReLU forward pipe.
// Used by relu_forward_pipe (optional stats: RELU_FWD_STATS_EN).
package relu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP32_NEG_INF  = 32'hFF80_0000;
  localparam int          FP32_BIAS     = 127;

  typedef enum logic [1:0] {
    LC_PASS,
    LC_ZERO,
    LC_NEGZ,
    LC_MUL
  } lane_cls_e;

  function automatic logic fp32_is_zero_or_denorm(input fp32_t v);
    return v.exp == 8'd0;
  endfunction

endpackage

// File: rtl/fp32_mul_trunc_2s.sv
// One lane of the leaky-ReLU: classify and multiply in S1,
// normalise, truncate and select in S2.
module fp32_mul_trunc_2s
  import relu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en_s1,
  input  logic        i_en_s2,
  input  logic        i_leaky,
  input  logic [31:0] i_a,
  input  logic [31:0] i_slope,
  output logic [31:0] o_res
);

  fp32_t              w_a;
  fp32_t              w_s;
  lane_cls_e          w_cls;
  logic [47:0]        w_prod;
  logic signed [9:0]  w_exp;
  logic               w_unused;

  lane_cls_e          r_cls;
  logic [31:0]        r_a;
  logic [24:0]        r_prod;
  logic signed [9:0]  r_exp;
  logic [31:0]        r_res;

  logic               w_norm;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_fexp;
  logic [31:0]        w_res;

  // Slope sign is ignored: the slope is always treated as positive.
  assign w_a      = i_a;
  assign w_s      = {1'b0, i_slope[30:0]};
  assign w_prod   = {24'd0, 1'b1, w_a.frac} * {24'd0, 1'b1, w_s.frac};
  assign w_exp    = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_s.exp})
                  - 10'(FP32_BIAS);
  assign w_unused = ^{i_slope[31], w_prod[22:0]};

  always_comb begin
    w_cls = LC_MUL;
    if (!w_a.sign || w_a.exp == 8'hFF)
      w_cls = LC_PASS;
    else if (!i_leaky)
      w_cls = LC_ZERO;
    else if (fp32_is_zero_or_denorm(w_a) || fp32_is_zero_or_denorm(w_s))
      w_cls = LC_NEGZ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cls  <= LC_PASS;
      r_a    <= '0;
      r_prod <= '0;
      r_exp  <= '0;
    end else if (i_en_s1) begin
      r_cls  <= w_cls;
      r_a    <= i_a;
      r_prod <= w_prod[47:23];
      r_exp  <= w_exp;
    end
  end

  assign w_norm = r_prod[24];
  assign w_frac = w_norm ? r_prod[23:1] : r_prod[22:0];
  assign w_fexp = r_exp + (w_norm ? 10'sd1 : 10'sd0);

  always_comb begin
    w_res = FP32_POS_ZERO;
    unique case (r_cls)
      LC_PASS: w_res = r_a;
      LC_ZERO: w_res = FP32_POS_ZERO;
      LC_NEGZ: w_res = FP32_NEG_ZERO;
      LC_MUL: begin
        if (w_fexp <= 10'sd0)
          w_res = FP32_NEG_ZERO;
        else if (w_fexp >= 10'sd255)
          w_res = FP32_NEG_INF;
        else
          w_res = {1'b1, w_fexp[7:0], w_frac};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_res <= '0;
    else if (i_en_s2)
      r_res <= w_res;
  end

  assign o_res = r_res;

endmodule

// File: rtl/relu_forward_pipe.sv
// Two-stage leaky-ReLU over NUM_LANES FP32 lanes with valid/ready flow.
// Define RELU_FWD_STATS_EN to add neg_count/beat_count outputs.
module relu_forward_pipe
  import relu_pkg::*;
#(
  parameter int          NUM_LANES = 4,
  parameter logic [31:0] DEF_SLOPE = 32'h38D1B717
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode_leaky,
  input  logic                   slope_sel,
  input  logic [31:0]            neg_slope,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NUM_LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NUM_LANES-1:0] out_data
`ifdef RELU_FWD_STATS_EN
  ,
  output logic [31:0]            neg_count,
  output logic [31:0]            beat_count
`endif
);

  logic        r_s1_valid;
  logic        r_s2_valid;
  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_in_fire;
  logic [31:0] w_slope;

  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_adv;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_in_fire = in_valid & in_ready;
  assign out_valid = r_s2_valid;
  assign w_slope   = slope_sel ? neg_slope : DEF_SLOPE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_ready)
        r_s1_valid <= in_valid;
      if (w_s2_adv)
        r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fp32_mul_trunc_2s u_mul (
      .clk     (clk),
      .reset   (reset),
      .i_en_s1 (w_in_fire),
      .i_en_s2 (w_s1_adv),
      .i_leaky (mode_leaky),
      .i_a     (in_data[32*g +: 32]),
      .i_slope (w_slope),
      .o_res   (out_data[32*g +: 32])
    );
  end

`ifdef RELU_FWD_STATS_EN
  logic        w_out_fire;
  logic [31:0] w_neg_in;
  logic [32:0] w_neg_sum;
  logic [31:0] r_neg_s1;
  logic [31:0] r_neg_s2;
  logic [31:0] r_neg_count;
  logic [31:0] r_beat_count;

  assign w_out_fire = r_s2_valid & out_ready;
  assign w_neg_sum  = {1'b0, r_neg_count} + {1'b0, r_neg_s2};

  // Negative finite lanes travel with their beat so counts match outputs.
  always_comb begin
    w_neg_in = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_data[32*i+31] && in_data[32*i+23 +: 8] != 8'hFF)
        w_neg_in = w_neg_in + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_s1     <= '0;
      r_neg_s2     <= '0;
      r_neg_count  <= '0;
      r_beat_count <= '0;
    end else begin
      if (w_in_fire)
        r_neg_s1 <= w_neg_in;
      if (w_s1_adv)
        r_neg_s2 <= r_neg_s1;
      if (w_out_fire) begin
        r_neg_count <= w_neg_sum[32] ? 32'hFFFF_FFFF : w_neg_sum[31:0];
        if (r_beat_count != 32'hFFFF_FFFF)
          r_beat_count <= r_beat_count + 32'd1;
      end
    end
  end

  assign neg_count  = r_neg_count;
  assign beat_count = r_beat_count;
`endif

endmodule

// File: tb/tb_relu_forward_pipe.sv
// Scoreboard bench for relu_forward_pipe: random and directed beats
// checked against a field-level FP32 leaky-ReLU reference model.
module tb_relu_forward_pipe;

  localparam int          NL  = 4;
  localparam logic [31:0] DEF = 32'h38D1B717;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode_leaky;
  logic            slope_sel;
  logic [31:0]     neg_slope;
  logic            in_valid;
  logic            in_ready;
  logic [32*NL-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [32*NL-1:0] out_data;
`ifdef RELU_FWD_STATS_EN
  logic [31:0]     neg_count;
  logic [31:0]     beat_count;
`endif

  relu_forward_pipe #(.NUM_LANES(NL), .DEF_SLOPE(DEF)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_leaky (mode_leaky),
    .slope_sel  (slope_sel),
    .neg_slope  (neg_slope),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef RELU_FWD_STATS_EN
    ,
    .neg_count  (neg_count),
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32*NL-1:0] data;
    int               issue;
    bit               chk;
    int               nneg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ready_low = 0;
  int   exp_neg = 0;
  int   exp_beat = 0;
  bit   mon_en = 0;
  bit   last_stall = 0;
  logic [32*NL-1:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_lane(input logic [31:0] a,
                                           input logic lk,
                                           input logic [31:0] s);
    logic [63:0] m;
    int          e;
    if (!a[31] || a[30:23] == 8'hFF) return a;
    if (!lk) return 32'h0000_0000;
    if (a[30:23] == 8'd0 || s[30:23] == 8'd0) return 32'h8000_0000;
    m = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, s[22:0]};
    e = int'(a[30:23]) + int'(s[30:23]) - 127;
    if (m >= 64'h8000_0000_0000) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return 32'h8000_0000;
    if (e >= 255) return 32'hFF80_0000;
    return {1'b1, 8'(e), m[45:23]};
  endfunction

  function automatic logic [32*NL-1:0] ref_beat(input logic [32*NL-1:0] d,
                                                input logic lk, sl,
                                                input logic [31:0] sp);
    logic [32*NL-1:0] r;
    logic [31:0]      s;
    s = sl ? {1'b0, sp[30:0]} : DEF;
    for (int i = 0; i < NL; i++)
      r[32*i +: 32] = ref_lane(d[32*i +: 32], lk, s);
    return r;
  endfunction

  function automatic int cnt_neg(input logic [32*NL-1:0] d);
    int n = 0;
    for (int i = 0; i < NL; i++)
      if (d[32*i+31] && d[32*i+23 +: 8] != 8'hFF) n++;
    return n;
  endfunction

  function automatic logic [32*NL-1:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rnd_lane();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'd0;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'($urandom_range(1, 10));
      3: v[30:23] = 8'($urandom_range(245, 254));
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic send(input logic [32*NL-1:0] d, input logic lk, sl,
                      input logic [31:0] sp, input logic [32*NL-1:0] e,
                      input bit chk);
    int   n;
    exp_t x;
    n = 0;
    in_data = d;
    mode_leaky = lk;
    slope_sel = sl;
    neg_slope = sp;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      ready_low++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles", n);
    end else begin
      x.data = e;
      x.issue = cyc;
      x.chk = chk;
      x.nneg = cnt_neg(d);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected beats on every output handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      if (last_stall) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", 128'(out_data), 128'(last_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          check("data", 128'(out_data), 128'(e.data));
          if (e.chk)
            check("latency", 128'(cyc - e.issue), 128'd2);
          exp_neg += e.nneg;
          exp_beat++;
        end
      end
      last_stall = out_valid && !out_ready;
      last_data = out_data;
    end else begin
      last_stall = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*NL-1:0] d;
    logic [31:0]      sp;
    logic             lk;
    logic             sl;
    int               rl0;
    bit               done;

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    mode_leaky = 1'b0;
    slope_sel = 1'b0;
    neg_slope = 32'h3F00_0000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    mon_en = 1;
    @(posedge clk);
    #1;

    send(pk(32'h3F800000, 32'hC0000000, 32'h80000000, 32'h7FC00000),
         1, 1, 32'h3F000000,
         pk(32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7FC00000), 1);
    send(pk(32'hC0000000, 32'hFF800000, 32'h3F800000, 32'h00000000),
         0, 1, 32'h3F000000,
         pk(32'h00000000, 32'hFF800000, 32'h3F800000, 32'h00000000), 1);
    send(pk(32'hBF800000, 32'h7F800000, 32'hFFC00001, 32'h00000001),
         1, 0, 32'h3F000000,
         pk(32'hB8D1B717, 32'h7F800000, 32'hFFC00001, 32'h00000001), 1);
    send(pk(32'h80800000, 32'h80000001, 32'hC0400000, 32'hFF800000),
         1, 1, 32'h3F000000,
         pk(32'h80000000, 32'h80000000, 32'hBFC00000, 32'hFF800000), 1);
    send(pk(32'hFF000000, 32'hBF800000, 32'hC0000000, 32'h40000000),
         1, 1, 32'h40000000,
         pk(32'hFF800000, 32'hC0000000, 32'hC0800000, 32'h40000000), 1);
    send(pk(32'hBF800000, 32'hC0000000, 32'hBF800000, 32'hBF800000),
         1, 1, 32'h00400000,
         pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 1);
    drain();

    rl0 = ready_low;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
          sp = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
          lk = 1'($urandom);
          sl = 1'($urandom);
          send(d, lk, sl, sp, ref_beat(d, lk, sl, sp), 0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_backpressure", 128'(ready_low > rl0), 128'd1);

    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          d = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
          sp = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
          lk = 1'($urandom);
          sl = 1'($urandom);
          send(d, lk, sl, sp, ref_beat(d, lk, sl, sp), 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    d = pk(32'h3F800000, 32'h40000000, 32'hC0000000, 32'h3F000000);
    send(d, 1, 1, 32'h3F000000, ref_beat(d, 1, 1, 32'h3F000000), 0);
    send(d, 1, 1, 32'h3F000000, ref_beat(d, 1, 1, 32'h3F000000), 0);
    reset = 1'b1;
    mon_en = 0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_neg = 0;
    exp_beat = 0;
    @(negedge clk);
    check("flush_out_valid", 128'(out_valid), 128'd0);
    check("flush_out_data", 128'(out_data), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    mon_en = 1;
    @(posedge clk);
    #1;
    d = pk(32'h3F800000, 32'hC0800000, 32'h00000000, 32'h41000000);
    send(d, 1, 1, 32'h3E800000, pk(32'h3F800000, 32'hBF800000,
         32'h00000000, 32'h41000000), 1);
    send(pk(32'hC0000000, 32'hBF800000, 32'h3F800000, 32'h7FC00000),
         1, 0, 32'h0,
         pk(32'hB951B717, 32'hB8D1B717, 32'h3F800000, 32'h7FC00000), 1);
    send(pk(32'h3F800000, 32'hFF800000, 32'h00000000, 32'h7F800000),
         1, 0, 32'h0,
         pk(32'h3F800000, 32'hFF800000, 32'h00000000, 32'h7F800000), 1);
    send(pk(32'hC0000000, 32'h80000000, 32'h80800000, 32'hFF000000),
         0, 0, 32'h0, 128'd0, 1);
    drain();
`ifdef RELU_FWD_STATS_EN
    check("neg_count", 128'(neg_count), 128'(exp_neg));
    check("beat_count", 128'(beat_count), 128'(exp_beat));
    check("neg_count_plan", 128'(neg_count), 128'd7);
`endif
    check("beats_after_reset", 128'(exp_beat), 128'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relu_forward_pipe.md
Name: relu_forward_pipe

Overview:
Parametrised, pipelined leaky-ReLU forward activation over NUM_LANES IEEE-754 single-precision lanes per beat. It is the successor to the single-cycle vector ReLU and sits between a convolution/FC accumulator output stream and the next layer's input buffer. It adds valid/ready handshakes with backpressure, a runtime ReLU/leaky mode, a runtime negative slope, and a real FP32 multiply for negative inputs.

Parameters:
NUM_LANES, 4, float lanes per beat (>=1)
DEF_SLOPE, 32'h38D1B717 (0.0001f), slope used when slope_sel=0

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
mode_leaky  in  1  1 = leaky ReLU, 0 = plain ReLU; sampled with each accepted beat
slope_sel  in  1  1 = use neg_slope port, 0 = DEF_SLOPE; sampled per beat
neg_slope  in  32  runtime FP32 slope; must be positive
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  32*NUM_LANES  packed FP32 lanes, lane 0 in bits [31:0]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  32*NUM_LANES  packed FP32 results

Behaviour:
- Reset, with reset=1 at a clock edge: out_valid=0, out_data=0, both stage-valid flags cleared. in_ready=1 from the first cycle after reset deasserts. Any in-flight data is discarded.
- Pipeline has 2 stages (S1, S2). Latency is exactly 2 cycles from input handshake to out_valid when out_ready=1.
- Transfers occur when valid and ready are both high. Stage k advances when it is empty or the stage after it advances.
- in_ready = ~S1_valid | S1_advance. Throughput is 1 beat/cycle.
- out_valid/out_data are held stable while out_valid=1 and out_ready=0.
- S1 operations:
  - Register the lanes, mode, and effective slope.
  - Compute per-lane sign/class.
  - Compute the 24x24 mantissa product and the raw exponent ea+es-127.
- S2 operations: normalise, truncate, select the result, and register to the outputs.
- Per-lane result:
  - sign=0 (including +0, +inf, +NaN): output = input unchanged.
  - sign=1, exp=255 (-inf or -NaN): output = input unchanged.
  - sign=1 and mode_leaky=0: output = 32'h0000_0000.
  - sign=1, mode_leaky=1, input zero/denormal or slope zero/denormal: output = 32'h8000_0000.
  - Otherwise, compute a product of input and slope with sign 1.
- Product arithmetic:
  - Form the 48-bit mantissa product. If bit 47 is set, shift right 1 and increment the exponent.
  - Round toward zero by truncating to 23 fraction bits.
  - If the final exponent is <=0, output 32'h8000_0000 (denormals flushed).
  - If the final exponent is >=255, output 32'hFF80_0000.
- Slope sign bit is ignored (treated as positive). A slope with exp=255 is undefined; verification must not drive it.
- Simultaneous events: S2 draining while S1 fills in the same cycle is legal and loses no beat. Reset has priority over any handshake in the same cycle.

Optional Feature:
RELU_FWD_STATS_EN.
- Defined: add output ports neg_count[31:0] and beat_count[31:0].
  - neg_count += number of lanes with sign=1 and exp!=255, counted on each output handshake.
  - beat_count += 1 per output handshake.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package relu_pkg contains:
  - typedef fp32_t (packed struct: sign, exp[7:0], frac[22:0]).
  - Constants FP32_POS_ZERO, FP32_NEG_ZERO, FP32_NEG_INF, FP32_BIAS=127.
  - Function fp32_is_zero_or_denorm.
- Sub-module fp32_mul_trunc_2s: one lane's 2-stage truncating multiply with an enable input. It is instantiated NUM_LANES times in a generate loop. The top module owns the handshake and lane select.

Test Plan:
1. Reset, then one beat with lanes {3F800000, C0000000, 80000000, 7FC00000}, mode_leaky=1, slope_sel=1, neg_slope=3F000000 -> out_data = {3F800000, BF800000, 80000000, 7FC00000} on the 2nd cycle after the handshake.
2. Lane C0000000 with mode_leaky=0 -> 00000000. Lane BF800000 with mode_leaky=1, slope_sel=0 -> B8D1B717. Lane FF800000 -> FF800000.
3. Underflow: lane 80800000 (-2^-126) with slope 3F000000 -> 80000000. Overflow: lane FF000000 with slope 40000000 -> FF800000.
4. Stream 8 back-to-back beats with out_ready held low for cycles 3-6 -> in_ready drops after 2 beats are buffered. No beat is lost or duplicated, order is preserved, and out_data is stable while stalled.
5. Assert reset with 2 beats in flight -> out_valid=0 on the next cycle, in_ready=1 the cycle after, and the first post-reset beat appears with latency 2.
6. With RELU_FWD_STATS_EN defined, pass 3 beats containing 2, 0 and 4 negative finite lanes -> neg_count=6, beat_count=3.
